// File: rtl/fast9_segment_test.sv
// fast9_segment_test: FAST-9 segment test for one candidate pixel.
// Classifies 16 streamed circle pixels as bright/dark against center +/- t,
// tracks the longest contiguous run (including the 15->0 wrap) and reports
// a registered one-cycle result.
// Ports:
//   clk, reset (async, active-high)
//   start, center[7:0], threshold[7:0]  - begin a candidate (IDLE only)
//   pix_valid, pix[7:0]                 - circle pixels 0..15 in order (LOAD only)
//   busy                                - candidate in progress
//   result_valid, is_corner, polarity, arc_len[4:0], pix_addr[14:0] - result
module fast9_segment_test #(
   parameter int unsigned IMG_PIXELS = 21600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  center,
   input  logic [7:0]  threshold,
   input  logic        pix_valid,
   input  logic [7:0]  pix,
   output logic        busy,
   output logic        result_valid,
   output logic        is_corner,
   output logic        polarity,
   output logic [4:0]  arc_len,
   output logic [14:0] pix_addr
);

   localparam int unsigned N_CIRCLE = 16;
   localparam int unsigned ARC_MIN  = 9;
   localparam int unsigned N_STORE  = 8;
   localparam int unsigned RUN_W    = 5;
   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned IDX_W    = 4;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRAP, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [7:0]          center_q, center_d;
   logic [7:0]          thr_q, thr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;       // pixel index in LOAD, replay index in WRAP
   logic [N_STORE-1:0]  bflag_q, bflag_d;
   logic [N_STORE-1:0]  dflag_q, dflag_d;
   logic [RUN_W-1:0]    brun_q, brun_d, bmax_q, bmax_d;
   logic [RUN_W-1:0]    drun_q, drun_d, dmax_q, dmax_d;
   logic                busy_q, busy_d;
   logic                rv_q, rv_d;
   logic                corner_q, corner_d;
   logic                pol_q, pol_d;
   logic [RUN_W-1:0]    len_q, len_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   // Classification against the latched center/threshold
   logic [8:0]          hi;
   logic signed [9:0]   lo;
   logic                bright_c, dark_c;

   assign hi       = {1'b0, center_q} + 9'(thr_q);
   assign lo       = signed'({2'b00, center_q}) - signed'({2'b00, thr_q});
   assign bright_c = ({1'b0, pix} > hi);
   // Negative lo means nothing can be darker
   assign dark_c   = !lo[9] && ({2'b00, pix} < unsigned'(lo));

   // Final arc length from the two run maxima, capped at the circle size
   logic [RUN_W-1:0]    max_c, len_c;
   assign max_c = (bmax_q > dmax_q) ? bmax_q : dmax_q;
   assign len_c = (max_c > RUN_W'(N_CIRCLE)) ? RUN_W'(N_CIRCLE) : max_c;

   logic step, fb, fd;

   // Next-state and datapath
   always_comb begin
      state_d  = state_q;
      center_d = center_q;
      thr_d    = thr_q;
      idx_d    = idx_q;
      bflag_d  = bflag_q;
      dflag_d  = dflag_q;
      brun_d   = brun_q;
      bmax_d   = bmax_q;
      drun_d   = drun_q;
      dmax_d   = dmax_q;
      busy_d   = busy_q;
      rv_d     = 1'b0;
      corner_d = corner_q;
      pol_d    = pol_q;
      len_d    = len_q;
      addr_d   = addr_q;
      step     = 1'b0;
      fb       = 1'b0;
      fd       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_LOAD;
               center_d = center;
               thr_d    = threshold;
               idx_d    = '0;
               bflag_d  = '0;
               dflag_d  = '0;
               brun_d   = '0;
               bmax_d   = '0;
               drun_d   = '0;
               dmax_d   = '0;
               busy_d   = 1'b1;
            end
         end
         S_LOAD: begin
            if (pix_valid) begin
               step = 1'b1;
               fb   = bright_c;
               fd   = dark_c;
               // Only the first 8 flags are needed to extend runs across 15->0
               if (idx_q < IDX_W'(N_STORE)) begin
                  bflag_d[idx_q[2:0]] = bright_c;
                  dflag_d[idx_q[2:0]] = dark_c;
               end
               if (idx_q == IDX_W'(N_CIRCLE - 1)) begin
                  state_d = S_WRAP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_WRAP: begin
            // Replay 0..7, then one cycle to register the settled maxima
            if (idx_q == IDX_W'(N_STORE)) begin
               state_d  = S_DONE;
               rv_d     = 1'b1;
               len_d    = len_c;
               corner_d = (len_c >= RUN_W'(ARC_MIN));
               pol_d    = (bmax_q >= RUN_W'(ARC_MIN));
            end else begin
               step  = 1'b1;
               fb    = bflag_q[idx_q[2:0]];
               fd    = dflag_q[idx_q[2:0]];
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            addr_d  = (addr_q == ADDR_W'(IMG_PIXELS - 1)) ? '0 : addr_q + ADDR_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // Saturating run counters with running maxima
      if (step) begin
         brun_d = fb ? ((brun_q == '1) ? brun_q : brun_q + RUN_W'(1)) : '0;
         drun_d = fd ? ((drun_q == '1) ? drun_q : drun_q + RUN_W'(1)) : '0;
         bmax_d = (brun_d > bmax_q) ? brun_d : bmax_q;
         dmax_d = (drun_d > dmax_q) ? drun_d : dmax_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         center_q <= '0;
         thr_q    <= '0;
         idx_q    <= '0;
         bflag_q  <= '0;
         dflag_q  <= '0;
         brun_q   <= '0;
         bmax_q   <= '0;
         drun_q   <= '0;
         dmax_q   <= '0;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
         corner_q <= 1'b0;
         pol_q    <= 1'b0;
         len_q    <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         center_q <= center_d;
         thr_q    <= thr_d;
         idx_q    <= idx_d;
         bflag_q  <= bflag_d;
         dflag_q  <= dflag_d;
         brun_q   <= brun_d;
         bmax_q   <= bmax_d;
         drun_q   <= drun_d;
         dmax_q   <= dmax_d;
         busy_q   <= busy_d;
         rv_q     <= rv_d;
         corner_q <= corner_d;
         pol_q    <= pol_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
      end
   end

   assign busy         = busy_q;
   assign result_valid = rv_q;
   assign is_corner    = corner_q;
   assign polarity     = pol_q;
   assign arc_len      = len_q;
   assign pix_addr     = addr_q;

endmodule

// File: tb/tb_fast9_segment_test.sv
// Directed bench for fast9_segment_test: the driver pushes hand-computed
// results into a scoreboard queue, the monitor pops on every result strobe.
// A second instance with a 4-pixel frame exercises the address wrap.
module tb_fast9_segment_test;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  center = '0;
   logic [7:0]  threshold = '0;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix = '0;

   logic        busy, result_valid, is_corner, polarity;
   logic [4:0]  arc_len;
   logic [14:0] pix_addr;
   logic        w_busy, w_result_valid, w_is_corner, w_polarity;
   logic [4:0]  w_arc_len;
   logic [14:0] w_pix_addr;

   fast9_segment_test dut (
      .clk(clk), .reset(reset), .start(start), .center(center),
      .threshold(threshold), .pix_valid(pix_valid), .pix(pix),
      .busy(busy), .result_valid(result_valid), .is_corner(is_corner),
      .polarity(polarity), .arc_len(arc_len), .pix_addr(pix_addr));

   fast9_segment_test #(.IMG_PIXELS(4)) dut_w (
      .clk(clk), .reset(reset), .start(start), .center(center),
      .threshold(threshold), .pix_valid(pix_valid), .pix(pix),
      .busy(w_busy), .result_valid(w_result_valid), .is_corner(w_is_corner),
      .polarity(w_polarity), .arc_len(w_arc_len), .pix_addr(w_pix_addr));

   always #5 clk = ~clk;

   typedef struct packed {
      logic        corner;
      logic        pol;
      logic [4:0]  len;
      logic [14:0] addr;
      logic [14:0] addr_w;
      int          ek;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          res_cnt = 0;
   logic [7:0]  pat [16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every result strobe must match the oldest expected entry
   always @(negedge clk) begin
      if (!reset && result_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_result: got result_valid=1 expected no result (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("is_corner", int'(is_corner), int'(e.corner));
            chk("polarity", int'(polarity), int'(e.pol));
            chk("arc_len", int'(arc_len), int'(e.len));
            chk("pix_addr", int'(pix_addr), int'(e.addr));
            chk("latency", cyc - e.ek, 9);
            chk("w_result_valid", int'(w_result_valid), 1);
            chk("w_pix_addr", int'(w_pix_addr), int'(e.addr_w));
            chk("w_arc_len", int'(w_arc_len), int'(e.len));
            chk("w_corner_pol", int'({w_is_corner, w_polarity}), int'({e.corner, e.pol}));
         end
      end
   end

   // Fill pattern with base, then n pixels of val starting at s (wrapping)
   task automatic mk(input logic [7:0] base, input logic [7:0] val, input int s, input int n);
      for (int k = 0; k < 16; k++) pat[k] = base;
      for (int k = 0; k < n; k++) pat[(s + k) % 16] = val;
   endtask

   task automatic run_cand(input logic [7:0] c, input logic [7:0] t, input bit gap,
                           input bit spur, input logic ec, input logic ep,
                           input logic [4:0] el);
      exp_t e;
      if (spur) begin
         // pixel offered in IDLE must be ignored
         @(posedge clk); #1;
         pix_valid = 1'b1; pix = 8'd200;
      end
      @(posedge clk); #1;
      start = 1'b1; center = c; threshold = t;
      pix_valid = 1'b1; pix = 8'd255;   // coincident with start: ignored
      @(posedge clk); #1;
      start = 1'b0; pix_valid = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      for (int i = 0; i < 16; i++) begin
         if (gap) begin
            for (int g = 0; g < 1 + (i % 3); g++) begin
               if (spur && i == 5 && g == 0) begin
                  start = 1'b1; center = 8'd0; threshold = 8'd0;
               end
               @(posedge clk); #1;
               start = 1'b0;
            end
         end
         pix_valid = 1'b1; pix = pat[i];
         if (i == 15) begin
            e.corner = ec; e.pol = ep; e.len = el;
            e.addr   = 15'(res_cnt % 21600);
            e.addr_w = 15'(res_cnt % 4);
            e.ek     = cyc + 1;
            sb.push_back(e);
            res_cnt++;
         end
         @(posedge clk); #1;
         pix_valid = 1'b0;
      end
      begin
         int n;
         for (n = 0; n < 40 && busy; n++) begin
            @(posedge clk); #1;
         end
         if (busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 40 cycles");
         end
      end
   endtask

   initial begin
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_result_valid", int'(result_valid), 0);
      chk("rst_outputs", int'({is_corner, polarity, arc_len}), 0);
      chk("rst_pix_addr", int'(pix_addr), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      mk(100, 121, 0, 9);   run_cand(100, 20, 0, 0, 1, 1, 9);    // bright corner
      mk(100, 79, 12, 9);   run_cand(100, 20, 0, 0, 1, 0, 9);    // wrapping dark
      mk(100, 120, 0, 9);   run_cand(100, 20, 0, 0, 0, 0, 0);    // equal to hi
      mk(100, 121, 0, 8);   run_cand(100, 20, 0, 0, 0, 0, 8);    // one short
      mk(200, 200, 0, 0);   run_cand(100, 20, 0, 0, 1, 1, 16);   // saturate/cap
      mk(0, 0, 0, 0);       run_cand(5, 10, 0, 0, 0, 0, 0);      // lo < 0
      mk(255, 255, 0, 0);   run_cand(250, 10, 0, 0, 0, 0, 0);    // hi > 255
      mk(100, 121, 0, 9);   run_cand(100, 20, 1, 0, 1, 1, 9);    // gapped stream
      mk(100, 121, 0, 9);   run_cand(100, 20, 1, 1, 1, 1, 9);    // spurious start/pix
      mk(100, 0, 3, 10);    run_cand(100, 20, 0, 0, 1, 0, 10);
      mk(100, 121, 10, 11); run_cand(100, 20, 0, 0, 1, 1, 11);   // bright wrap

      // Reset in the middle of LOAD: no result, outputs cleared
      @(posedge clk); #1;
      start = 1'b1; center = 8'd100; threshold = 8'd20;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pix_valid = 1'b1; pix = 8'd121;
         @(posedge clk); #1;
      end
      pix_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_w_busy", int'(w_busy), 0);
      chk("abort_result_valid", int'(result_valid), 0);
      chk("abort_outputs", int'({is_corner, polarity, arc_len}), 0);
      chk("abort_pix_addr", int'(pix_addr), 0);
      sb.delete();
      res_cnt = 0;
      @(posedge clk); #1;
      reset = 1'b0;

      mk(100, 121, 0, 9);   run_cand(100, 20, 0, 0, 1, 1, 9);    // addr back to 0
      for (int k = 0; k < 16; k++) pat[k] = (k % 2 == 0) ? 8'd121 : 8'd79;
      run_cand(100, 20, 0, 0, 0, 0, 1);                          // alternating
      mk(100, 79, 13, 8);   run_cand(100, 20, 0, 0, 0, 0, 8);    // dark wrap, short
      mk(0, 0, 0, 0);       run_cand(20, 20, 0, 0, 0, 0, 0);     // lo == 0
      mk(100, 121, 7, 9);   run_cand(100, 20, 1, 0, 1, 1, 9);    // 5th result: w wraps

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      chk("idle_busy", int'(busy), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish before 2ms");
      $fatal(1);
   end

endmodule
